// File: rtl/fifo_pkt_defs.sv
// Frame definitions shared by the packet framer and the matching deframer:
// FSM state encodings, the default sync byte and the trailer checksum rule.
package fifo_pkt_defs;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_LEN     = 3'd3,
    ST_CHK     = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;

  // CHK covers the payload bytes plus the LEN byte, wrapping mod 256.
  function automatic logic [7:0] frame_chk(input logic [7:0] payload_sum,
                                           input logic [7:0] len);
    return payload_sum + len;
  endfunction

endpackage

// File: rtl/fifo_pkt_framer.sv
// Drains a first-word-fall-through FIFO into SYNC, payload, LEN, CHK frames; 2-cycle
// start latency, then 1 byte/cycle. A stalled output slot holds its byte and stops pops.
module fifo_pkt_framer
  import fifo_pkt_defs::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DFLT,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_fifo_data,
  input  logic       i_fifo_empty,
  output logic       o_fifo_rd,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int              TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_B    = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             is_chk_q, is_chk_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       chk_q, chk_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             slot_free;
  logic             fifo_rd;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    is_chk_d  = is_chk_q;
    cnt_d     = cnt_q;
    chk_d     = chk_q;
    tmo_d     = tmo_q;
    fifo_rd   = 1'b0;
    slot_free = !valid_q || i_ready;

    // An accepted byte empties the slot unless a new byte is loaded below.
    if (slot_free) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        chk_d = 8'd0;
        tmo_d = '0;
        if (!i_fifo_empty) begin
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (slot_free) begin
          valid_d  = 1'b1;
          data_d   = SYNC_BYTE;
          is_chk_d = 1'b0;
          tmo_d    = '0;
          state_d  = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (slot_free && !i_fifo_empty && (cnt_q < MAX_LEN_B)) begin
          fifo_rd  = 1'b1;
          valid_d  = 1'b1;
          data_d   = i_fifo_data;
          is_chk_d = 1'b0;
          cnt_d    = cnt_q + 8'd1;
          chk_d    = chk_q + i_fifo_data;
          tmo_d    = '0;
          if (cnt_q + 8'd1 == MAX_LEN_B) begin
            state_d = ST_LEN;
          end
        end else if (i_fifo_empty) begin
          // Entry to PAYLOAD needs a non-empty FIFO, so a timeout always has cnt >= 1.
          tmo_d = tmo_q + TMO_ONE;
          if (tmo_q + TMO_ONE == TMO_B) begin
            state_d = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        if (slot_free) begin
          valid_d  = 1'b1;
          data_d   = cnt_q;
          is_chk_d = 1'b0;
          state_d  = ST_CHK;
        end
      end
      ST_CHK: begin
        if (slot_free) begin
          valid_d  = 1'b1;
          data_d   = frame_chk(chk_q, cnt_q);
          is_chk_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      is_chk_q <= 1'b0;
      cnt_q    <= 8'd0;
      chk_q    <= 8'd0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      is_chk_q <= is_chk_d;
      cnt_q    <= cnt_d;
      chk_q    <= chk_d;
      tmo_q    <= tmo_d;
    end
  end

  assign o_fifo_rd    = fifo_rd && !i_rst;
  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_busy       = busy_q;
  assign o_frame_done = valid_q && is_chk_q && i_ready;

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Bench for fifo_pkt_framer: behavioural FWFT FIFO, scoreboard of expected frame bytes,
// one task per scenario.
module tb_fifo_pkt_framer;

  localparam int MAXL = 4;
  localparam int TMO  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] o_data;
  logic       o_valid;
  logic       ready;
  logic       busy;
  logic       frame_done;

  fifo_pkt_framer #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAXL), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_fifo_data(fifo_data), .i_fifo_empty(fifo_empty),
    .o_fifo_rd(fifo_rd), .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
    .o_busy(busy), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         last;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fq[$];
  logic [7:0] pend[$];
  logic [7:0] outq[$];
  logic [7:0] ref_q[$];
  int         acc_steps[$];

  int  tests_run = 0;
  int  tests_failed = 0;
  int  pops, uf_viol, fd_viol, step_cnt, first_vld, last_acc;
  bit  sb_en, prev_stall;
  logic [7:0] prev_d;

  task automatic sb_push(input logic [7:0] d, input bit last);
    exp_t e;
    e.d = d;
    e.last = last;
    sb.push_back(e);
  endtask

  // Everything already queued in the FIFO is framed in MAX_LEN chunks; a short tail closes by timeout.
  task automatic expect_frames();
    int n;
    logic [7:0] sum, b;
    while (pend.size() > 0) begin
      n = (pend.size() > MAXL) ? MAXL : pend.size();
      sum = 8'd0;
      sb_push(8'hA5, 1'b0);
      for (int i = 0; i < n; i++) begin
        b = pend.pop_front();
        sum = sum + b;
        sb_push(b, 1'b0);
      end
      sb_push(8'(n), 1'b0);
      sb_push(sum + 8'(n), 1'b1);
    end
  endtask

  task automatic add_byte(input logic [7:0] b);
    fq.push_back(b);
    pend.push_back(b);
  endtask

  task automatic step(input bit rdy);
    bit rd, acc, fd;
    logic [7:0] d;
    exp_t e;
    @(negedge clk);
    ready = rdy;
    fifo_empty = (fq.size() == 0);
    fifo_data = fifo_empty ? 8'h00 : fq[0];
    #1;
    rd = fifo_rd;
    acc = o_valid && ready;
    d = o_data;
    fd = frame_done;
    if (rd && fifo_empty) uf_viol++;
    if (fd && !acc) fd_viol++;
    if (prev_stall) begin
      tests_run++;
      if (o_valid !== 1'b1 || d !== prev_d) begin
        tests_failed++;
        $display("FAIL stall_hold: o_valid=%0b o_data=%02h, required 1/%02h", o_valid, d, prev_d);
      end
    end
    prev_stall = o_valid && !ready;
    prev_d = d;
    if (o_valid && first_vld < 0) first_vld = step_cnt;
    if (acc) begin
      outq.push_back(d);
      acc_steps.push_back(step_cnt);
      last_acc = step_cnt;
      if (sb_en) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_byte: got %02h with scoreboard empty", d);
        end else begin
          e = sb.pop_front();
          if (d !== e.d || fd !== e.last) begin
            tests_failed++;
            $display("FAIL scoreboard: byte %02h done %0b, required %02h done %0b", d, fd, e.d, e.last);
          end
        end
      end
    end
    @(posedge clk);
    if (rd) begin
      pops++;
      if (fq.size() > 0) void'(fq.pop_front());
    end
    step_cnt++;
  endtask

  task automatic drain(input bit toggle);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      step(toggle ? (n % 2 == 0) : 1'b1);
      #1;
      if (sb.size() == 0 && fq.size() == 0 && !busy && !o_valid) begin
        ok = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d bytes still expected, busy=%0b", sb.size(), busy);
    end
  endtask

  task automatic begin_test();
    pops = 0; uf_viol = 0; fd_viol = 0; step_cnt = 0; first_vld = -1; last_acc = -1;
    prev_stall = 1'b0; sb_en = 1'b1;
    outq.delete(); acc_steps.delete(); sb.delete(); pend.delete();
  endtask

  task automatic check_val(input string name, input int got, input int want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic check_out(input string name);
    check_val({name, "_len"}, outq.size(), ref_q.size());
    if (outq.size() == ref_q.size()) begin
      foreach (ref_q[i]) check_val({name, "_byte"}, int'(outq[i]), int'(ref_q[i]));
    end
  endtask

  task automatic end_checks(input string name, input int exp_pops);
    check_val({name, "_underflow"}, uf_viol, 0);
    check_val({name, "_done_stray"}, fd_viol, 0);
    check_val({name, "_pops"}, pops, exp_pops);
    check_val({name, "_busy_end"}, int'(busy), 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1; fifo_empty = 1'b0; fifo_data = 8'h33;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", int'(o_valid), 0);
    check_val("rst_data", int'(o_data), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(frame_done), 0);
    check_val("rst_rd", int'(fifo_rd), 0);
    fifo_empty = 1'b1; fifo_data = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    begin_test();
    for (int i = 1; i <= 4; i++) add_byte(8'(i));
    expect_frames();
    drain(1'b0);
    ref_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h0E};
    check_out("single");
    check_val("single_latency", first_vld, 2);
    check_val("single_last_step", last_acc, 8);
    end_checks("single", 4);
  endtask

  task automatic test_timeout();
    begin_test();
    add_byte(8'h10);
    expect_frames();
    drain(1'b0);
    ref_q = '{8'hA5, 8'h10, 8'h01, 8'h11};
    check_out("timeout");
    if (acc_steps.size() == 4) check_val("timeout_gap", acc_steps[2] - acc_steps[1], TMO + 1);
    end_checks("timeout", 1);
  endtask

  task automatic test_back_to_back(input bit toggle, input string name);
    begin_test();
    for (int i = 1; i <= 6; i++) add_byte(8'(i));
    expect_frames();
    drain(toggle);
    ref_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h0E,
              8'hA5, 8'h05, 8'h06, 8'h02, 8'h0D};
    check_out(name);
    end_checks(name, 6);
  endtask

  task automatic test_wrap();
    begin_test();
    add_byte(8'hFF);
    add_byte(8'hFF);
    expect_frames();
    drain(1'b0);
    ref_q = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h00};
    check_out("wrap");
    end_checks("wrap", 2);
  endtask

  task automatic test_reset_midframe();
    begin_test();
    sb_en = 1'b0;
    for (int i = 1; i <= 4; i++) fq.push_back(8'(i));
    for (int n = 0; n < 20 && outq.size() < 3; n++) step(1'b1);
    check_val("midrst_pre_bytes", outq.size(), 3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_valid", int'(o_valid), 0);
    check_val("midrst_busy", int'(busy), 0);
    check_val("midrst_rd", int'(fifo_rd), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    outq.delete();
    sb_en = 1'b1;
    pend = fq;
    expect_frames();
    drain(1'b0);
    check_val("midrst_len", outq.size(), 4);
    if (outq.size() > 0) check_val("midrst_first", int'(outq[0]), 8'hA5);
    check_val("midrst_underflow", uf_viol, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_timeout();
    test_back_to_back(1'b0, "b2b");
    test_back_to_back(1'b1, "stall");
    test_wrap();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_framer.md
FIFO_PKT_FRAMER -- requirements
Module: fifo_pkt_framer

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: first byte of every frame.
REQ-002 Parameter MAX_LEN, default 16, legal range 1..255: maximum payload bytes per frame.
REQ-003 Parameter TIMEOUT, default 16, legal range >=1: consecutive FIFO-empty cycles that close a partial frame.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_fifo_data  in  8  syncfifo o_data; first-word-fall-through, valid whenever i_fifo_empty=0.
REQ-007 i_fifo_empty  in  1  syncfifo o_empty.
REQ-008 o_fifo_rd  out  1  pop strobe to syncfifo i_rd; the head byte is consumed at the clock edge where this is 1.
REQ-009 o_data  out  8  framed output byte.
REQ-010 o_valid  out  1  o_data valid.
REQ-011 i_ready  in  1  downstream accepts o_data when o_valid && i_ready at a clock edge.
REQ-012 o_busy  out  1  high in every state except IDLE.
REQ-013 o_frame_done  out  1  one-cycle pulse on the edge where the CHK byte is accepted.

Function
REQ-014 Frame format SHALL be SYNC_BYTE, payload[0..N-1], LEN=N, CHK; 1<=N<=MAX_LEN; CHK = (sum of payload bytes + LEN) mod 256.
REQ-015 States SHALL be IDLE, SYNC, PAYLOAD, LEN, CHK.
REQ-016 Output slot: o_data/o_valid registered; slot free when !o_valid || i_ready; o_data SHALL stay stable while o_valid && !i_ready.
REQ-017 Transitions: IDLE->SYNC when !i_fifo_empty. SYNC loads SYNC_BYTE into a free slot, then goes to PAYLOAD. PAYLOAD->LEN when the payload count reaches MAX_LEN or TIMEOUT is reached. LEN->CHK and CHK->IDLE each occur when the corresponding byte is loaded into a free slot.
REQ-018 In PAYLOAD, o_fifo_rd SHALL be 1 combinationally iff slot free && !i_fifo_empty && count<MAX_LEN. In that cycle: i_fifo_data loads into o_data, the payload count increments, and the byte is added to the checksum.
REQ-019 o_fifo_rd SHALL never assert while i_fifo_empty=1 and never outside PAYLOAD, so no underflow is possible.
REQ-020 Timeout counter: cleared on every pop and on entry to PAYLOAD; increments on every PAYLOAD cycle with i_fifo_empty=1; after TIMEOUT consecutive empty cycles the state goes to LEN. Payload count is >=1 here by construction.
REQ-021 Latency: the first SYNC_BYTE SHALL appear on o_valid 2 cycles after i_fifo_empty falls in IDLE, given i_ready=1. At i_ready=1 with the FIFO non-empty, throughput SHALL be one byte per cycle with no bubbles between frames other than the IDLE->SYNC cycle.
REQ-022 The payload counter SHALL be 8 bits and the checksum accumulator 8 bits, wrapping mod 256.
REQ-023 The last payload pop and the transition to LEN in the same cycle SHALL be legal; the LEN byte follows on the next free slot.
REQ-024 Simultaneous slot accept and new load SHALL not lose or duplicate bytes.

Reset
REQ-025 i_rst=1 SHALL force, asynchronously: state IDLE, o_valid=0, o_data=0, o_frame_done=0, o_busy=0, counters=0, checksum=0. o_fifo_rd=0 while reset is asserted.
REQ-026 Reset mid-frame SHALL abandon the frame; no trailer is emitted. The next frame starts with SYNC_BYTE.

Structure
REQ-027 State encodings and the SYNC_BYTE default SHALL live in a shared definitions header, fifo_pkt_defs, for reuse by the matching deframer.
REQ-028 No internal sub-module; syncfifo is instantiated alongside by the parent. Checksum and timeout logic are inline.

Verification (MAX_LEN=4, TIMEOUT=8, SYNC_BYTE=A5)
REQ-029 FIFO holds 01 02 03 04, i_ready=1 -> A5 01 02 03 04 04 0E, o_frame_done on the 0E cycle, 4 pops total.
REQ-030 Single byte 10 then empty -> A5 10, then after 8 empty cycles 01 11, then IDLE with o_busy=0.
REQ-031 FIFO holds 01..06 -> A5 01 02 03 04 04 0E, then A5 05 06 02 0D.
REQ-032 Case 031 with i_ready toggling 1/0 every cycle -> identical byte sequence; o_data stable while stalled; 6 pops exactly.
REQ-033 Payload FF FF then timeout -> A5 FF FF 02 00 (checksum wrap).
REQ-034 Assert i_rst after the 2nd payload byte -> o_valid=0 the same cycle; after release with the FIFO non-empty, the next output is A5. Check o_fifo_rd&&i_fifo_empty is never true across all scenarios.
